// File: rtl/rans_decoder.sv
// rans_decoder: single-stream rANS decoder.
// It takes the encoder byte stream in decode order (last byte emitted comes first)
// and returns the original symbols through a valid/ready handshake.
// Optional feature macro: RANS_SLOT_LUT_EN.
//   Defined   : a slot->symbol LUT is filled on every table write, and LOOKUP takes one cycle.
//   Undefined : LOOKUP scans the frequency table linearly from index 0, one entry per cycle.
module rans_decoder #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    freq_wr_i,
    input  logic [SYMBOL_WIDTH-1:0] symb_i,
    input  logic [RESOLUTION-1:0]   freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    output logic                    tbl_busy_o,
    input  logic                    start_i,
    input  logic [15:0]             num_symb_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    byte_ready_o,
    output logic                    symb_valid_o,
    output logic [SYMBOL_WIDTH-1:0] symb_o,
    input  logic                    symb_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int          DEPTH   = 1 << SYMBOL_WIDTH;
    localparam logic [31:0] L_BOUND = 32'h0080_0000;

    typedef enum logic [2:0] {IDLE, INIT, LOOKUP, EMIT, UPDATE, RENORM, CHECK} state_t;

    state_t                  state_reg, state_next;
    logic [31:0]             x_reg, x_next;
    logic [15:0]             cnt_reg, cnt_next;
    logic [1:0]              bcnt_reg, bcnt_next;
    logic [RESOLUTION-1:0]   freq_reg, freq_next;
    logic [RESOLUTION-1:0]   cum_reg, cum_next;
    logic                    err_reg, err_next;

    // The frequency and cumulative tables are deliberately left out of reset.
    // Their contents survive rst_i.
    logic [RESOLUTION-1:0]   freq_mem [DEPTH];
    logic [RESOLUTION-1:0]   cum_mem  [DEPTH];

    logic                    tbl_busy;
    logic                    tbl_wr;
    logic [RESOLUTION-1:0]   slot;
    logic [SYMBOL_WIDTH-1:0] cur_sym;

    assign tbl_wr = freq_wr_i && (state_reg == IDLE) && !tbl_busy;
    assign slot   = x_reg[RESOLUTION-1:0];

    // Store the frequency and cumulative frequency of a symbol on each accepted table write.
    always_ff @(posedge clk_i) begin
        if (tbl_wr) begin
            freq_mem[symb_i] <= freq_i;
            cum_mem[symb_i]  <= cum_freq_i;
        end
    end

`ifdef RANS_SLOT_LUT_EN
    localparam int SLOTS = 1 << RESOLUTION;

    logic [SYMBOL_WIDTH-1:0] slot_lut [SLOTS];
    logic [SYMBOL_WIDTH-1:0] fill_sym_reg;
    logic [RESOLUTION-1:0]   fill_ptr_reg;
    logic [RESOLUTION-1:0]   fill_cnt_reg;
    logic [SYMBOL_WIDTH-1:0] lut_q;

    assign tbl_busy = (fill_cnt_reg != '0);
    assign cur_sym  = lut_q;

    // Fill sequencer: walk the slots cum..cum+freq-1 of the symbol just written, one slot per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_sym_reg <= '0;
            fill_ptr_reg <= '0;
            fill_cnt_reg <= '0;
        end else if (tbl_wr) begin
            fill_sym_reg <= symb_i;
            fill_ptr_reg <= cum_freq_i;
            fill_cnt_reg <= freq_i;
        end else if (fill_cnt_reg != '0) begin
            fill_ptr_reg <= fill_ptr_reg + 1'b1;
            fill_cnt_reg <= fill_cnt_reg - 1'b1;
        end
    end

    // Slot LUT: write port driven by the fill sequencer, registered read in LOOKUP.
    always_ff @(posedge clk_i) begin
        if (fill_cnt_reg != '0) begin
            slot_lut[fill_ptr_reg] <= fill_sym_reg;
        end
        if (state_reg == LOOKUP) begin
            lut_q <= slot_lut[slot];
        end
    end
`else
    localparam logic [SYMBOL_WIDTH-1:0] IDX_ONE = 1;

    logic [SYMBOL_WIDTH-1:0] sym_reg, sym_next;
    logic [SYMBOL_WIDTH-1:0] idx_reg, idx_next;
    logic [RESOLUTION-1:0]   f_s, c_s;
    logic [RESOLUTION:0]     c_end;
    logic                    hit;

    assign tbl_busy = 1'b0;
    assign cur_sym  = sym_reg;

    // The search tests one entry per cycle, so the table is read asynchronously.
    // An entry with freq = 0 has an empty interval and never matches.
    assign f_s   = freq_mem[idx_reg];
    assign c_s   = cum_mem[idx_reg];
    assign c_end = {1'b0, c_s} + {1'b0, f_s};
    assign hit   = (f_s != '0) && (slot >= c_s) && ({1'b0, slot} < c_end);

    // Search state: index of the entry being tested and the symbol found.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sym_reg <= '0;
            idx_reg <= '0;
        end else begin
            sym_reg <= sym_next;
            idx_reg <= idx_next;
        end
    end
`endif

    // State register and decoder datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            cnt_reg   <= '0;
            bcnt_reg  <= '0;
            freq_reg  <= '0;
            cum_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            cnt_reg   <= cnt_next;
            bcnt_reg  <= bcnt_next;
            freq_reg  <= freq_next;
            cum_reg   <= cum_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic and datapath updates for the decode sequence.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        cnt_next   = cnt_reg;
        bcnt_next  = bcnt_reg;
        freq_next  = freq_reg;
        cum_next   = cum_reg;
        err_next   = err_reg;
`ifndef RANS_SLOT_LUT_EN
        sym_next   = sym_reg;
        idx_next   = '0;
`endif
        case (state_reg)
            IDLE: begin
                if (start_i && !tbl_busy) begin
                    err_next   = 1'b0;
                    cnt_next   = num_symb_i;
                    bcnt_next  = '0;
                    x_next     = '0;
                    state_next = INIT;
                end
            end
            INIT: begin
                // Bytes arrive MSB first: x = {b0, b1, b2, b3}.
                if (byte_valid_i) begin
                    x_next    = {x_reg[23:0], byte_i};
                    bcnt_next = bcnt_reg + 2'd1;
                    if (bcnt_reg == 2'd3) begin
                        state_next = (cnt_reg == 16'd0) ? CHECK : LOOKUP;
                    end
                end
            end
            LOOKUP: begin
`ifdef RANS_SLOT_LUT_EN
                state_next = EMIT;
`else
                if (hit) begin
                    sym_next   = idx_reg;
                    freq_next  = f_s;
                    cum_next   = c_s;
                    state_next = EMIT;
                end else if (idx_reg == '1) begin
                    err_next   = 1'b1;
                    state_next = CHECK;
                end else begin
                    idx_next = idx_reg + IDX_ONE;
                end
`endif
            end
            EMIT: begin
`ifdef RANS_SLOT_LUT_EN
                // The symbol is known from the LUT.
                // Fetch its frequency and cumulative frequency while the consumer decides.
                freq_next = freq_mem[lut_q];
                cum_next  = cum_mem[lut_q];
`endif
                if (symb_ready_i) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                x_next     = 32'(freq_reg) * (x_reg >> RESOLUTION) + 32'(slot) - 32'(cum_reg);
                cnt_next   = cnt_reg - 16'd1;
                state_next = RENORM;
            end
            RENORM: begin
                if (x_reg < L_BOUND) begin
                    if (byte_valid_i) begin
                        x_next = {x_reg[23:0], byte_i};
                    end
                end else if (cnt_reg == 16'd0) begin
                    state_next = CHECK;
                end else begin
                    state_next = LOOKUP;
                end
            end
            CHECK: begin
                if (x_reg != L_BOUND) begin
                    err_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is a function of registered state only.
    // The error term from CHECK is folded into err_o so that it appears together with done_o.
    assign busy_o       = (state_reg != IDLE);
    assign done_o       = (state_reg == CHECK);
    assign err_o        = err_reg || ((state_reg == CHECK) && (x_reg != L_BOUND));
    assign byte_ready_o = (state_reg == INIT) || ((state_reg == RENORM) && (x_reg < L_BOUND));
    assign symb_valid_o = (state_reg == EMIT);
    assign symb_o       = (state_reg == EMIT) ? cur_sym : '0;
    assign tbl_busy_o   = tbl_busy;

endmodule

// File: tb/tb_rans_decoder.sv
// Directed testbench for rans_decoder.
// It loads the three-symbol table, decodes hand-computed frames, and checks the outputs.
module tb_rans_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        freq_wr_i = 1'b0;
    logic [7:0]  symb_i = '0;
    logic [9:0]  freq_i = '0;
    logic [9:0]  cum_freq_i = '0;
    logic        tbl_busy_o;
    logic        start_i = 1'b0;
    logic [15:0] num_symb_i = '0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = '0;
    logic        byte_ready_o;
    logic        symb_valid_o;
    logic [7:0]  symb_o;
    logic        symb_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] byte_vec [8];
    logic [7:0] exp_sym  [4];

    rans_decoder #(.RESOLUTION(10), .SYMBOL_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .freq_wr_i   (freq_wr_i),
        .symb_i      (symb_i),
        .freq_i      (freq_i),
        .cum_freq_i  (cum_freq_i),
        .tbl_busy_o  (tbl_busy_o),
        .start_i     (start_i),
        .num_symb_i  (num_symb_i),
        .byte_valid_i(byte_valid_i),
        .byte_i      (byte_i),
        .byte_ready_o(byte_ready_o),
        .symb_valid_o(symb_valid_o),
        .symb_o      (symb_o),
        .symb_ready_i(symb_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},       busy_o,       32'd0);
        check({tag, " byte_ready"}, byte_ready_o, 32'd0);
        check({tag, " symb_valid"}, symb_valid_o, 32'd0);
        check({tag, " symb"},       symb_o,       32'd0);
        check({tag, " done"},       done_o,       32'd0);
        check({tag, " err"},        err_o,        32'd0);
        check({tag, " tbl_busy"},   tbl_busy_o,   32'd0);
    endtask

    task automatic load_table();
        for (int s = 0; s < 256; s++) begin
            freq_wr_i = 1'b1;
            symb_i    = 8'(s);
            case (s)
                8'h41:   begin freq_i = 10'd512; cum_freq_i = 10'd0;   end
                8'h42:   begin freq_i = 10'd256; cum_freq_i = 10'd512; end
                8'h43:   begin freq_i = 10'd256; cum_freq_i = 10'd768; end
                default: begin freq_i = 10'd0;   cum_freq_i = 10'd0;   end
            endcase
            @(posedge clk_i); #1;
            freq_wr_i = 1'b0;
            for (int k = 0; k < 2000 && tbl_busy_o; k++) begin
                @(posedge clk_i); #1;
            end
        end
        check("table load tbl_busy", tbl_busy_o, 32'd0);
    endtask

    task automatic start_frame(input string name, input int num);
        start_i      = 1'b1;
        num_symb_i   = 16'(num);
        byte_valid_i = 1'b0;
        symb_ready_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check({name, " busy after start"}, busy_o, 32'd1);
        check({name, " err cleared"},      err_o,  32'd0);
    endtask

    task automatic run_frame(input string name, input int num, input int nbytes,
                             input int nsym, input logic exp_err, input int stall);
        int bidx = 0;
        int sidx = 0;
        int stall_left = stall;
        bit seen_done = 1'b0;
        bit take_byte;
        start_frame(name, num);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done_o) begin
                seen_done = 1'b1;
                break;
            end
            if (symb_valid_o && stall_left > 0) begin
                for (int k = 0; k < stall_left; k++) begin
                    symb_ready_i = 1'b0;
                    byte_valid_i = 1'b1;
                    byte_i       = 8'hEE;
                    @(posedge clk_i); #1;
                    check({name, " stall valid"},      symb_valid_o, 32'd1);
                    check({name, " stall symb"},       symb_o,       32'(exp_sym[sidx]));
                    check({name, " stall byte_ready"}, byte_ready_o, 32'd0);
                end
                stall_left = 0;
            end
            take_byte    = byte_ready_o;
            byte_valid_i = 1'b1;
            byte_i       = (bidx < nbytes) ? byte_vec[bidx] : 8'hEE;
            symb_ready_i = 1'b1;
            if (symb_valid_o) begin
                $display("%s: symbol %0d = 0x%02h", name, sidx, symb_o);
                if (sidx < nsym) begin
                    check({name, " symbol"}, symb_o, 32'(exp_sym[sidx]));
                end else begin
                    check({name, " extra symbol"}, 32'(sidx + 1), 32'(nsym));
                end
                sidx++;
            end
            @(posedge clk_i); #1;
            if (take_byte) bidx++;
        end
        byte_valid_i = 1'b0;
        check({name, " done seen"},      32'(seen_done), 32'd1);
        check({name, " err at done"},    err_o,          32'(exp_err));
        check({name, " bytes consumed"}, 32'(bidx),      32'(nbytes));
        check({name, " symbols"},        32'(sidx),      32'(nsym));
        @(posedge clk_i); #1;
        check({name, " idle busy"},   busy_o, 32'd0);
        check({name, " done pulse"},  done_o, 32'd0);
        check({name, " err sticky"},  err_o,  32'(exp_err));
        $display("%s: frame ended err=%0d bytes=%0d symbols=%0d", name, err_o, bidx, sidx);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_idle_outputs("reset");
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        load_table();

        // Frame 1: x = 0x01000000, slot 0 -> 'A', x' = 512*0x4000 = L
        byte_vec[0] = 8'h01; byte_vec[1] = 8'h00; byte_vec[2] = 8'h00; byte_vec[3] = 8'h00;
        exp_sym[0]  = 8'h41;
        run_frame("f1", 1, 4, 1, 1'b0, 0);

        // Frame 2: x = 0x04000400 -> 'A', x = 0x2000200 -> 'B', x = 0x800000
        byte_vec[0] = 8'h04; byte_vec[1] = 8'h00; byte_vec[2] = 8'h04; byte_vec[3] = 8'h00;
        exp_sym[0]  = 8'h41; exp_sym[1] = 8'h42;
        run_frame("f2", 2, 4, 2, 1'b0, 0);

        // Frame 3: x = 0x00800000 -> 'A', x = 0x400000 < L; 0x5A pulled in RENORM
        byte_vec[0] = 8'h00; byte_vec[1] = 8'h80; byte_vec[2] = 8'h00; byte_vec[3] = 8'h00;
        byte_vec[4] = 8'h5A;
        exp_sym[0]  = 8'h41;
        run_frame("f3", 1, 5, 1, 1'b1, 0);

        // Frame 4: x = 0x01000001 -> 'A', final x = 0x800001
        byte_vec[0] = 8'h01; byte_vec[1] = 8'h00; byte_vec[2] = 8'h00; byte_vec[3] = 8'h01;
        exp_sym[0]  = 8'h41;
        run_frame("f4", 1, 4, 1, 1'b1, 0);

        // Frame 5: as frame 1, but the consumer stalls for 10 cycles in EMIT
        byte_vec[0] = 8'h01; byte_vec[1] = 8'h00; byte_vec[2] = 8'h00; byte_vec[3] = 8'h00;
        exp_sym[0]  = 8'h41;
        run_frame("f5 stall", 1, 4, 1, 1'b0, 10);

        // Reset in the middle of INIT, then decode frame 2 again without reloading the table
        start_frame("rst", 1);
        byte_valid_i = 1'b1; byte_i = 8'h01;
        @(posedge clk_i); #1;
        byte_i = 8'h00;
        @(posedge clk_i); #1;
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check_idle_outputs("mid-frame reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check_idle_outputs("after reset");

        byte_vec[0] = 8'h04; byte_vec[1] = 8'h00; byte_vec[2] = 8'h04; byte_vec[3] = 8'h00;
        exp_sym[0]  = 8'h41; exp_sym[1] = 8'h42;
        run_frame("f6 post-reset", 2, 4, 2, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
